// File: rtl/mrelbp_pkg.sv
// Shared widths and loader state encoding for the MRELBP dense-weight LUT.
package mrelbp_pkg;

  localparam int unsigned WEIGHT_W   = 24;
  localparam int unsigned LUT_DEPTH  = 256;
  localparam int unsigned LUT_ADDR_W = 8;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned LD_CNT_W   = 2;

  typedef enum logic [1:0] {
    LD_IDLE,
    LD_LOAD,
    LD_DONE
  } ld_state_e;

endpackage

// File: rtl/lut_rd_loader_if.sv
// Byte-stream load channel plus combinational table read port.
//   i_byte_valid / i_byte / o_byte_ready : valid/ready byte stream, MSB byte of each word first
//   i_addr / o_dout                      : table read address and data
// Signal prefixes are from the loader's point of view.
interface lut_rd_loader_if;

  logic                                  i_byte_valid;
  logic [mrelbp_pkg::BYTE_W-1:0]         i_byte;
  logic                                  o_byte_ready;
  logic [mrelbp_pkg::LUT_ADDR_W-1:0]     i_addr;
  logic [mrelbp_pkg::WEIGHT_W-1:0]       o_dout;

  modport slave (
    input  i_byte_valid, i_byte, i_addr,
    output o_byte_ready, o_dout
  );

  modport master (
    output i_byte_valid, i_byte, i_addr,
    input  o_byte_ready, o_dout
  );

endinterface

// File: rtl/lut_rd_loader_weight_ram.sv
// Weight table storage: one synchronous write port, one asynchronous read port.
//   i_clk            : write clock
//   i_we/i_waddr/i_wdata : write port
//   i_raddr/o_rdata  : combinational read port
// The array has no reset; contents survive rst_n.
module weight_ram #(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/lut_rd_loader.sv
// Runtime loader for the dense-weight LUT: packs a byte stream into words and
// writes them to addresses 0..DEPTH-1, while serving combinational reads.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_start        : 1-cycle pulse, starts or restarts a load (wins over a same-cycle accept)
//   lut_if         : byte stream (valid/ready) and read port (addr -> dout)
//   o_loaded       : table fully written since the last start
//   o_done         : 1-cycle pulse after the last word is written
module lut_rd_loader
  import mrelbp_pkg::*;
#(
  parameter int unsigned DATA_W = WEIGHT_W,
  parameter int unsigned DEPTH  = LUT_DEPTH,
  parameter int unsigned ADDR_W = LUT_ADDR_W
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  lut_rd_loader_if.slave   lut_if,
  output logic             o_loaded,
  output logic             o_done
);

  localparam int unsigned PACK_W = DATA_W - BYTE_W;
  localparam int unsigned BYTES  = DATA_W / BYTE_W;

  localparam logic [1:0] S_IDLE = 2'(LD_IDLE);
  localparam logic [1:0] S_LOAD = 2'(LD_LOAD);
  localparam logic [1:0] S_DONE = 2'(LD_DONE);

  localparam logic [LD_CNT_W-1:0] LAST_CNT  = LD_CNT_W'(BYTES - 1);
  localparam logic [ADDR_W-1:0]   LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [1:0]          r_state,      w_state_nxt;
  logic [ADDR_W-1:0]   r_wr_addr,    w_wr_addr_nxt;
  logic [LD_CNT_W-1:0] r_byte_cnt,   w_byte_cnt_nxt;
  logic [PACK_W-1:0]   r_pack,       w_pack_nxt;
  logic                r_loaded,     w_loaded_nxt;
  logic                r_done,       w_done_nxt;
  logic                r_byte_ready, w_byte_ready_nxt;

  logic                w_accept;
  logic                w_we;
  logic [DATA_W-1:0]   w_wdata;

  assign w_accept = lut_if.i_byte_valid & r_byte_ready;
  assign w_wdata  = {r_pack, lut_if.i_byte};

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_wr_addr    <= '0;
      r_byte_cnt   <= '0;
      r_pack       <= '0;
      r_loaded     <= 1'b0;
      r_done       <= 1'b0;
      r_byte_ready <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_wr_addr    <= w_wr_addr_nxt;
      r_byte_cnt   <= w_byte_cnt_nxt;
      r_pack       <= w_pack_nxt;
      r_loaded     <= w_loaded_nxt;
      r_done       <= w_done_nxt;
      r_byte_ready <= w_byte_ready_nxt;
    end
  end

  // Next-state, packer, address counter and flags
  always_comb begin
    w_state_nxt    = r_state;
    w_wr_addr_nxt  = r_wr_addr;
    w_byte_cnt_nxt = r_byte_cnt;
    w_pack_nxt     = r_pack;
    w_loaded_nxt   = r_loaded;
    w_done_nxt     = 1'b0;
    w_we           = 1'b0;

    if (i_start) begin
      // Restart from any state; a byte offered this cycle is dropped.
      w_state_nxt    = S_LOAD;
      w_wr_addr_nxt  = '0;
      w_byte_cnt_nxt = '0;
      w_loaded_nxt   = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: ;
        S_LOAD: begin
          if (w_accept) begin
            // Keep only the most recent PACK_W bits of the byte history.
            w_pack_nxt = PACK_W'({r_pack, lut_if.i_byte});
            if (r_byte_cnt == LAST_CNT) begin
              w_we           = 1'b1;
              w_byte_cnt_nxt = '0;
              if (r_wr_addr == LAST_ADDR) begin
                w_state_nxt  = S_DONE;
                w_loaded_nxt = 1'b1;
                w_done_nxt   = 1'b1;
              end else begin
                w_wr_addr_nxt = r_wr_addr + ADDR_W'(1);
              end
            end else begin
              w_byte_cnt_nxt = r_byte_cnt + LD_CNT_W'(1);
            end
          end
        end
        S_DONE: ;
        default: w_state_nxt = S_IDLE;
      endcase
    end

    w_byte_ready_nxt = (w_state_nxt == S_LOAD);
  end

  weight_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (w_we),
    .i_waddr (r_wr_addr),
    .i_wdata (w_wdata),
    .i_raddr (lut_if.i_addr),
    .o_rdata (lut_if.o_dout)
  );

  assign lut_if.o_byte_ready = r_byte_ready;
  assign o_loaded            = r_loaded;
  assign o_done              = r_done;

endmodule

// File: tb/tb_lut_rd_loader.sv
// Randomized bench for lut_rd_loader against a byte-count based table model.
module tb_lut_rd_loader;
  import mrelbp_pkg::*;

  localparam int NBYTES = 768;

  logic i_clk = 1'b0;
  logic i_rst_n;
  logic i_start;
  logic o_loaded;
  logic o_done;

  always #5 i_clk = ~i_clk;

  lut_rd_loader_if u_if();

  lut_rd_loader u_dut (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_start  (i_start),
    .lut_if   (u_if),
    .o_loaded (o_loaded),
    .o_done   (o_done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: loading flag, bytes accepted since start, expected table.
  bit          m_ready, m_loaded, m_done;
  int          m_cnt;
  logic [23:0] m_word;
  logic [23:0] m_mem [256];
  bit          m_wr  [256];
  int          dut_acc, dut_done;

  function automatic logic [7:0] pat(input int k, input logic [7:0] salt);
    logic [7:0] n;
    n = 8'(k / 3);
    case (k % 3)
      0:       return n ^ salt;
      1:       return ~n ^ salt;
      default: return n ^ 8'h5A ^ salt;
    endcase
  endfunction

  task automatic step(input logic st, input logic v, input logic [7:0] b);
    bit   acc;
    logic [7:0] a;
    a = 8'($urandom_range(255));
    i_start = st;
    u_if.i_byte_valid = v;
    u_if.i_byte = b;
    u_if.i_addr = a;
    #1;
    if (v && u_if.o_byte_ready && !st) dut_acc++;
    acc = v && m_ready && !st;
    m_done = 1'b0;
    if (st) begin
      m_ready = 1'b1; m_loaded = 1'b0; m_cnt = 0; m_word = '0;
    end else if (acc) begin
      m_word = {m_word[15:0], b};
      m_cnt++;
      if (m_cnt % 3 == 0) begin
        m_mem[m_cnt/3 - 1] = m_word;
        m_wr[m_cnt/3 - 1]  = 1'b1;
        if (m_cnt == NBYTES) begin
          m_ready = 1'b0; m_loaded = 1'b1; m_done = 1'b1;
        end
      end
    end
    @(posedge i_clk); #1;
    if (o_done === 1'b1) dut_done++;
    check_val("ready",  u_if.o_byte_ready, m_ready);
    check_val("loaded", o_loaded, m_loaded);
    check_val("done",   o_done, m_done);
    if (m_wr[a]) check_val("rd_dout", u_if.o_dout, m_mem[a]);
  endtask

  task automatic load(input int target, input int gap_pct, input logic [7:0] salt);
    int cyc = 0;
    while (m_ready && m_cnt < target && cyc < 5000) begin
      step(1'b0, 1'($urandom_range(99) >= gap_pct), pat(m_cnt, salt));
      cyc++;
    end
  endtask

  task automatic check_table();
    i_start = 1'b0;
    u_if.i_byte_valid = 1'b0;
    for (int a = 0; a < 256; a++) begin
      u_if.i_addr = 8'(a);
      #1;
      if (m_wr[a]) check_val("table", u_if.o_dout, m_mem[a]);
    end
    @(negedge i_clk);
  endtask

  task automatic check_addr(input logic [7:0] a, input logic [23:0] exp);
    u_if.i_addr = a;
    #1;
    check_val("addr_const", u_if.o_dout, exp);
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    m_ready = 1'b0; m_loaded = 1'b0; m_done = 1'b0; m_cnt = 0;
    #2;
    check_val("rst_ready",  u_if.o_byte_ready, 1'b0);
    check_val("rst_loaded", o_loaded, 1'b0);
    check_val("rst_done",   o_done, 1'b0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_start = 1'b0;
    u_if.i_byte_valid = 1'b0;
    u_if.i_byte = '0;
    u_if.i_addr = '0;
    for (int a = 0; a < 256; a++) begin m_wr[a] = 1'b0; m_mem[a] = '0; end
    #12;
    do_reset();

    // Bytes without a start are ignored.
    dut_acc = 0;
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 8'($urandom_range(255)));
    check_val("idle_acc", 32'(dut_acc), 0);

    // Full load, no gaps.
    dut_acc = 0; dut_done = 0;
    step(1'b1, 1'b0, 8'h00);
    load(NBYTES, 0, 8'h00);
    step(1'b0, 1'b1, 8'hAB);
    step(1'b0, 1'b1, 8'hCD);
    check_val("nogap_acc",  32'(dut_acc), NBYTES);
    check_val("nogap_done", 32'(dut_done), 1);
    check_addr(8'h00, 24'h00FF5A);
    check_addr(8'hFF, 24'hFF00A5);
    check_table();

    // Full load with ~30% idle cycles.
    dut_acc = 0; dut_done = 0;
    step(1'b1, 1'b0, 8'h00);
    load(NBYTES, 30, 8'h00);
    step(1'b0, 1'b1, 8'h12);
    check_val("gap_acc",  32'(dut_acc), NBYTES);
    check_val("gap_done", 32'(dut_done), 1);
    check_addr(8'h00, 24'h00FF5A);
    check_addr(8'h80, 24'h807FDA);
    check_table();

    // Restart after 100 bytes with a different payload, then full reload.
    dut_done = 0;
    step(1'b1, 1'b0, 8'h00);
    load(100, 20, 8'h3C);
    step(1'b1, 1'b1, pat(100, 8'h3C));
    load(NBYTES, 0, 8'h00);
    check_val("abort_done", 32'(dut_done), 1);
    check_addr(8'h00, 24'h00FF5A);
    check_table();

    // Start coincident with the last byte: no write, no done.
    dut_done = 0;
    step(1'b1, 1'b0, 8'h00);
    load(NBYTES - 1, 0, 8'h77);
    step(1'b1, 1'b1, pat(NBYTES - 1, 8'h77));
    check_val("coinc_done", 32'(dut_done), 0);
    load(NBYTES, 10, 8'h00);
    check_val("coinc_reload_done", 32'(dut_done), 1);
    check_table();

    // Async reset mid-load, then a full load.
    dut_done = 0;
    step(1'b1, 1'b0, 8'h00);
    load(300, 0, 8'h11);
    do_reset();
    step(1'b1, 1'b0, 8'h00);
    load(NBYTES, 25, 8'h00);
    check_val("rst_reload_done", 32'(dut_done), 1);
    check_addr(8'hFF, 24'hFF00A5);
    check_table();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
